// File: rtl/hgcal_input_packer_if.sv
// Beat stream in, packed vector out, plus error flag/clear (and optional counters under HGCAL_PACKER_FRAME_CNT_EN).
// master = upstream/downstream environment, slave = packer.
interface hgcal_input_packer_if #(
  parameter int BEAT_W    = 16,
  parameter int NUM_BEATS = 6
);
  localparam int OUT_W = BEAT_W * NUM_BEATS;

  logic              in_valid;
  logic              in_ready;
  logic [BEAT_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic              err_sticky;
  logic              err_clr;
`ifdef HGCAL_PACKER_FRAME_CNT_EN
  logic [15:0]       frame_cnt;
  logic [7:0]        drop_cnt;

  modport master (
    output in_valid, in_data, in_last, out_ready, err_clr,
    input  in_ready, out_valid, out_data, err_sticky, frame_cnt, drop_cnt
  );
  modport slave (
    input  in_valid, in_data, in_last, out_ready, err_clr,
    output in_ready, out_valid, out_data, err_sticky, frame_cnt, drop_cnt
  );
`else
  modport master (
    output in_valid, in_data, in_last, out_ready, err_clr,
    input  in_ready, out_valid, out_data, err_sticky
  );
  modport slave (
    input  in_valid, in_data, in_last, out_ready, err_clr,
    output in_ready, out_valid, out_data, err_sticky
  );
`endif
endinterface

// File: rtl/hgcal_input_packer.sv
// Packs NUM_BEATS beats into one OUT_W vector for layer-0 LUT neurons; drops misaligned frames.
// Latency 1 clock from last beat to out_valid; vector held until out_ready, in_ready=out_ready while full.
// HGCAL_PACKER_FRAME_CNT_EN adds frame_cnt (handshakes) and drop_cnt (frame errors).
module hgcal_input_packer #(
  parameter int BEAT_W    = 16,
  parameter int NUM_BEATS = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hgcal_input_packer_if.slave  bus
);
  localparam int OUT_W = BEAT_W * NUM_BEATS;
  localparam int CNT_W = $clog2(NUM_BEATS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BEATS - 1);

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_FULL = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic             err_q, err_d;

  logic             in_rdy;
  logic             accept;
  logic             out_hs;
  logic [CNT_W-1:0] idx;
  logic             frame_err;
  logic             wr_beat;

  // A beat taken in the handshake cycle of a full vector always starts a new frame at slice 0.
  assign in_rdy    = (state_q == ST_FULL) ? bus.out_ready : 1'b1;
  assign accept    = bus.in_valid && in_rdy;
  assign out_hs    = (state_q == ST_FULL) && bus.out_ready;
  assign idx       = (state_q == ST_FULL) ? '0 : cnt_q;
  assign frame_err = accept && (bus.in_last != (idx == LAST_IDX));
  assign wr_beat   = accept && !frame_err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    for (int b = 0; b < NUM_BEATS; b++) begin
      if (wr_beat && (idx == CNT_W'(b))) begin
        data_d[b*BEAT_W +: BEAT_W] = bus.in_data;
      end
    end
    if (out_hs) begin
      state_d = ST_FILL;
      cnt_d   = '0;
    end
    if (wr_beat) begin
      if (idx == LAST_IDX) begin
        state_d = ST_FULL;
        cnt_d   = '0;
      end else begin
        cnt_d = idx + CNT_W'(1);
      end
    end else if (frame_err) begin
      cnt_d = '0;
    end
  end

  assign err_d = frame_err | (err_q & ~bus.err_clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FILL;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready   = in_rdy;
  assign bus.out_valid  = (state_q == ST_FULL);
  assign bus.out_data   = data_q;
  assign bus.err_sticky = err_q;

`ifdef HGCAL_PACKER_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]  drop_cnt_q, drop_cnt_d;

  // Like err_sticky, a new drop in the err_clr cycle takes priority over the clear.
  always_comb begin
    frame_cnt_d = frame_cnt_q + (out_hs ? 16'd1 : 16'd0);
    drop_cnt_d  = drop_cnt_q;
    if (frame_err) begin
      if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end else if (bus.err_clr) begin
      drop_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= 16'd0;
      drop_cnt_q  <= 8'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign bus.frame_cnt = frame_cnt_q;
  assign bus.drop_cnt  = drop_cnt_q;
`endif
endmodule

// File: tb/tb_hgcal_input_packer.sv
// Directed stimulus with a scoreboard queue of expected vectors; a negedge monitor pops on each out handshake.
module tb_hgcal_input_packer;
  localparam int BEAT_W    = 16;
  localparam int NUM_BEATS = 6;
  localparam int OUT_W     = BEAT_W * NUM_BEATS;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   stalls   = 0;

  logic [OUT_W-1:0] exp_q[$];
  logic [OUT_W-1:0] mon_exp;

  hgcal_input_packer_if #(.BEAT_W(BEAT_W), .NUM_BEATS(NUM_BEATS)) bus ();

  hgcal_input_packer #(.BEAT_W(BEAT_W), .NUM_BEATS(NUM_BEATS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    int n;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      stalls++;
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout beat=%h in_ready=%b required=1", d, bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] base, input logic [OUT_W-1:0] exp);
    for (int i = 1; i < NUM_BEATS; i++) send(base | 16'(i), 1'b0);
    exp_q.push_back(exp);
    send(base | 16'(NUM_BEATS), 1'b1);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out out_data=%h required=no output", bus.out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("out_data", 128'(bus.out_data), 128'(mon_exp));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    bus.err_clr   = 1'b0;
    #2;
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_out_data", 128'(bus.out_data), 128'(0));
    chk("rst_err_sticky", 128'(bus.err_sticky), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(bus.in_ready), 128'(1));

    // Basic frame, latency 1 and drop after handshake
    bus.out_ready = 1'b1;
    send_frame(16'h0000, 96'h0006_0005_0004_0003_0002_0001);
    chk("lat_out_valid_rise", 128'(bus.out_valid), 128'(1));
    @(posedge clk);
    #1;
    chk("out_valid_fall", 128'(bus.out_valid), 128'(0));

    // Stall for 10 cycles with beats offered
    bus.out_ready = 1'b0;
    send_frame(16'h0010, 96'h0016_0015_0014_0013_0012_0011);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 16'hBEEF;
      bus.in_last  = 1'b1;
      @(negedge clk);
      chk("stall_in_ready", 128'(bus.in_ready), 128'(0));
      chk("stall_out_valid", 128'(bus.out_valid), 128'(1));
      chk("stall_out_data", 128'(bus.out_data), 128'(96'h0016_0015_0014_0013_0012_0011));
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("stall_release_fall", 128'(bus.out_valid), 128'(0));
    chk("stall_no_err", 128'(bus.err_sticky), 128'(0));

    // Back-to-back frames: no bubble
    stalls = 0;
    send_frame(16'h0100, 96'h0106_0105_0104_0103_0102_0101);
    send_frame(16'h0200, 96'h0206_0205_0204_0203_0202_0201);
    @(posedge clk);
    #1;
    chk("b2b_stalls", 128'(stalls), 128'(0));
    chk("b2b_no_err", 128'(bus.err_sticky), 128'(0));

    // Early in_last on beat 3
    send(16'h0A01, 1'b0);
    send(16'h0A02, 1'b0);
    send(16'h0A03, 1'b1);
    chk("early_last_err", 128'(bus.err_sticky), 128'(1));
    chk("early_last_no_valid", 128'(bus.out_valid), 128'(0));
    send_frame(16'h0B00, 96'h0B06_0B05_0B04_0B03_0B02_0B01);
    @(posedge clk);
    #1;

    // Clear, then missing in_last on beat 6
    bus.err_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.err_clr = 1'b0;
    chk("err_clr", 128'(bus.err_sticky), 128'(0));
    for (int i = 1; i <= NUM_BEATS; i++) send(16'h0E00 | 16'(i), 1'b0);
    chk("missing_last_err", 128'(bus.err_sticky), 128'(1));
    chk("missing_last_no_valid", 128'(bus.out_valid), 128'(0));
    send_frame(16'h0F00, 96'h0F06_0F05_0F04_0F03_0F02_0F01);
    @(posedge clk);
    #1;

    // Clear coinciding with a new error: error wins
    bus.err_clr = 1'b1;
    send(16'h1234, 1'b1);
    bus.err_clr = 1'b0;
    chk("clr_vs_err", 128'(bus.err_sticky), 128'(1));

    // Asynchronous reset mid-frame
    for (int i = 1; i <= 4; i++) send(16'h0C00 | 16'(i), 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_data", 128'(bus.out_data), 128'(0));
    chk("async_rst_err", 128'(bus.err_sticky), 128'(0));
    chk("async_rst_out_valid", 128'(bus.out_valid), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_frame(16'h0D00, 96'h0D06_0D05_0D04_0D03_0D02_0D01);
    @(posedge clk);
    #1;

    // Two more good frames and one error since reset
    send_frame(16'h0300, 96'h0306_0305_0304_0303_0302_0301);
    send_frame(16'h0400, 96'h0406_0405_0404_0403_0402_0401);
    @(posedge clk);
    #1;
    send(16'h0501, 1'b1);
    chk("cnt_phase_err", 128'(bus.err_sticky), 128'(1));
`ifdef HGCAL_PACKER_FRAME_CNT_EN
    chk("frame_cnt", 128'(bus.frame_cnt), 128'(3));
    chk("drop_cnt", 128'(bus.drop_cnt), 128'(1));
`endif
    bus.err_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.err_clr = 1'b0;
    chk("final_err_clr", 128'(bus.err_sticky), 128'(0));
`ifdef HGCAL_PACKER_FRAME_CNT_EN
    chk("drop_cnt_clr", 128'(bus.drop_cnt), 128'(0));
    chk("frame_cnt_hold", 128'(bus.frame_cnt), 128'(3));
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
